acond_botones: RTL
==================

Name: acond_botones

Overview:
- Button conditioner between the raw board pushbuttons (Comida, Medicina, Test) and the pet state machine / mode controller.
- Synchronises, debounces and edge-detects each button, then emits clean single-cycle event pulses.
- Separates a short Test press from a long Test hold, so the downstream FSM consumes clean events instead of raw, bouncing levels.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a level change (hardware build uses 500000 at 50 MHz).
- LONG_PRESS_CYCLES, 64, debounced-hold cycles on Test that make a long press (hardware 2500000). Must exceed DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Boton_Comida  in  1  raw, asynchronous, bouncing button.
- Boton_Medicina  in  1  raw, asynchronous, bouncing button.
- Boton_Test  in  1  raw, asynchronous, bouncing button.
- Pulso_Comida  out  1  one-cycle pulse per accepted Comida press.
- Pulso_Medicina  out  1  one-cycle pulse per accepted Medicina press.
- Pulso_Test  out  1  one-cycle pulse per short Test press, issued on release.
- Test_Largo  out  1  one-cycle pulse when a Test hold reaches LONG_PRESS_CYCLES.
- Nivel_Test  out  1  debounced Test level, 1 = pressed.

Behaviour:
- Reset (synchronous, active-high), while asserted:
  - all outputs 0;
  - synchroniser flops and stable levels forced to "released";
  - debounce and hold counters 0;
  - Test FSM in REPOSO; pending-Medicina flag cleared.
- Input path, per button:
  - 2-flop synchroniser, then polarity normalisation (pressed = 1).
- Debounce, per button:
  - counter runs while the synchronised level differs from the stable level;
  - any cycle where they match clears the counter;
  - when the counter reaches DEBOUNCE_CYCLES-1 and the levels still differ, the stable level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change the stable level.
- Edge detect:
  - registered; a pulse is 1 in the cycle after the stable level flips.
  - Latency from the first edge sampling the new raw level to the pulse: exactly DEBOUNCE_CYCLES+3 cycles.
- Comida / Medicina:
  - each pulses on the stable released→pressed transition only;
  - releases produce nothing.
- Same-cycle collision:
  - if Comida and Medicina pulses would fire in the same cycle, Pulso_Comida fires and Pulso_Medicina fires in the next cycle via a pending flag;
  - the two never overlap.
  - A pending Medicina is not lost if another Comida press arrives in the next cycle; that is impossible anyway given debounce.
- Test FSM, on the debounced level:
  - REPOSO: on stable press → PULSADO, hold counter = 0.
  - PULSADO: hold counter +1 per cycle.
    - Stable release before the counter reaches LONG_PRESS_CYCLES-1 → Pulso_Test for 1 cycle, then REPOSO.
    - Counter reaching LONG_PRESS_CYCLES-1 → Test_Largo for 1 cycle, then LARGO.
  - LARGO: counter frozen; no further pulses however long the hold lasts. Stable release → REPOSO with no Pulso_Test.
  - Pulso_Test and Test_Largo are mutually exclusive per press.
- Nivel_Test equals the Test stable level, with the same registered delay as the edge path.
- Counter widths:
  - $clog2 of the respective parameter, plus 1;
  - counters saturate and never wrap.
- Reset mid-operation:
  - all in-flight debounce and hold state is discarded; no pulse is emitted during reset.
  - A button still held when reset drops is treated as a fresh press: one press pulse DEBOUNCE_CYCLES+3 cycles after the first non-reset edge.
  - For Test held through reset, the hold count restarts from 0.

Test Plan:
- DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1, reset high for 5 cycles then low, all buttons 1 → all outputs 0 for 100 cycles.
- Boton_Comida 1→0, held 30 cycles → Pulso_Comida high for exactly 1 cycle, 7 cycles after the first edge sampling 0; nothing on release.
- Boton_Medicina toggled every 2 cycles for 20 cycles, then held at 1 → no Pulso_Medicina.
- Boton_Comida and Boton_Medicina both 1→0 on the same edge → Pulso_Comida at cycle +7, Pulso_Medicina at cycle +8.
- Boton_Test low 10 cycles then high → Pulso_Test once, 7 cycles after release, Test_Largo never. Boton_Test low 60 cycles → Test_Largo once, Nivel_Test high for the hold, no Pulso_Test after release.
- Boton_Test held low across a 3-cycle reset pulse midway through a 15-cycle hold → no output during reset, hold count restarts, Test_Largo 20 cycles after the new debounced press if still held.

Source files
------------

// File: rtl/acond_botones.sv
// Button conditioner: synchronises, debounces and edge-detects the Comida, Medicina
// and Test pushbuttons, producing single-cycle events plus short/long Test detection.
module acond_botones #(
  parameter int unsigned DEBOUNCE_CYCLES   = 16,
  parameter int unsigned LONG_PRESS_CYCLES = 64,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic Boton_Comida,
  input  logic Boton_Medicina,
  input  logic Boton_Test,
  output logic Pulso_Comida,
  output logic Pulso_Medicina,
  output logic Pulso_Test,
  output logic Test_Largo,
  output logic Nivel_Test
);

  localparam int unsigned NB = 3;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned LW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam int unsigned IDX_COM = 0;
  localparam int unsigned IDX_MED = 1;
  localparam int unsigned IDX_TST = 2;
  localparam logic [NB-1:0] RAW_IDLE = {NB{ACTIVE_LOW}};
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    PULSADO = 2'd1,
    LARGO   = 2'd2
  } test_state_e;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] lvl;
  logic [NB-1:0] stable;
  logic [NB-1:0] prev;
  logic [NB-1:0] rise_c;
  logic [NB-1:0] fall_c;
  logic [DW-1:0] deb_cnt [NB];
  logic          pend_med;

  test_state_e   state;
  test_state_e   state_next;
  logic [LW-1:0] hold;
  logic [LW-1:0] hold_next;
  logic          pulso_test_c;
  logic          test_largo_c;

  assign raw = {Boton_Test, Boton_Medicina, Boton_Comida};

  // Two-flop synchroniser followed by a registered polarity normalisation (pressed = 1)
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RAW_IDLE;
      sync2 <= RAW_IDLE;
      lvl   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl   <= sync2 ^ RAW_IDLE;
    end
  end

  // Debounce: the stable level only follows after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < NB; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (lvl[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] >= DEB_LAST) begin
          stable[i]  <= lvl[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) prev <= '0;
    else       prev <= stable;
  end

  assign rise_c = stable & ~prev;
  assign fall_c = ~stable & prev;

  // Comida wins a same-cycle collision; Medicina is deferred one cycle via pend_med
  always_ff @(posedge clk) begin
    if (reset) begin
      Pulso_Comida   <= 1'b0;
      Pulso_Medicina <= 1'b0;
      pend_med       <= 1'b0;
    end else begin
      Pulso_Comida   <= rise_c[IDX_COM];
      Pulso_Medicina <= (rise_c[IDX_MED] | pend_med) & ~rise_c[IDX_COM];
      pend_med       <= (rise_c[IDX_MED] | pend_med) & rise_c[IDX_COM];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= REPOSO;
      hold  <= '0;
    end else begin
      state <= state_next;
      hold  <= hold_next;
    end
  end

  always_comb begin
    state_next = state;
    hold_next  = hold;
    case (state)
      REPOSO: begin
        if (rise_c[IDX_TST]) begin
          state_next = PULSADO;
          hold_next  = '0;
        end
      end
      PULSADO: begin
        if (fall_c[IDX_TST])      state_next = REPOSO;
        else if (hold >= HOLD_LAST) state_next = LARGO;
        else                      hold_next  = hold + LW'(1);
      end
      LARGO: begin
        if (fall_c[IDX_TST]) state_next = REPOSO;
      end
      default: state_next = REPOSO;
    endcase
  end

  always_comb begin
    pulso_test_c = 1'b0;
    test_largo_c = 1'b0;
    if (state == PULSADO) begin
      pulso_test_c = fall_c[IDX_TST];
      test_largo_c = ~fall_c[IDX_TST] & (hold >= HOLD_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Pulso_Test <= 1'b0;
      Test_Largo <= 1'b0;
    end else begin
      Pulso_Test <= pulso_test_c;
      Test_Largo <= test_largo_c;
    end
  end

  assign Nivel_Test = prev[IDX_TST];

endmodule
